// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: queues scan-code bytes in a small FIFO and
// serialises each as an 11-bit frame, driving both ps2_clk and ps2_data.
module ps2_device_tx #(
    parameter int CLK_DIV    = 8,
    parameter int GAP_CYCLES = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       ovf_clr,
    input  logic       host_inhibit,
    output logic       full,
    output logic       empty,
    output logic       busy,
    output logic       overflow,
    output logic       ps2_clk,
    output logic       ps2_data
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLK_DIV > GAP_CYCLES ? CLK_DIV : GAP_CYCLES) + 1;
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(FIFO_DEPTH);
    localparam logic [CW-1:0] DIV_LD   = CW'(CLK_DIV - 1);
    localparam logic [CW-1:0] GAP_LD   = CW'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {IDLE, SETUP, LOW, HIGH, GAP} state_t;

    state_t        state;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt, cnt_nxt;
    logic [CW-1:0] tmr;
    logic [10:0]   sr;
    logic [3:0]    nbit;
    logic [1:0]    inh_s;
    logic [7:0]    head;
    logic          pop, push;

    assign head = mem[rp];
    assign pop  = (state == IDLE) && (cnt != '0) && !inh_s[1];
    // A pop in the same cycle frees a slot, so a write to a full FIFO still lands.
    assign push = wr_en && ((cnt != FULL_CNT) || pop);

    always_comb begin
        cnt_nxt = cnt;
        if (push && !pop)
            cnt_nxt = cnt + 1'b1;
        else if (pop && !push)
            cnt_nxt = cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wp] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
            inh_s    <= '0;
        end else begin
            inh_s <= {inh_s[0], host_inhibit};
            if (push)
                wp <= wp + 1'b1;
            if (pop)
                rp <= rp + 1'b1;
            cnt   <= cnt_nxt;
            full  <= (cnt_nxt == FULL_CNT);
            empty <= (cnt_nxt == '0);
            if (wr_en && !push)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!clrn) begin
            state    <= IDLE;
            tmr      <= '0;
            sr       <= '1;
            nbit     <= '0;
            ps2_clk  <= 1'b1;
            ps2_data <= 1'b1;
            busy     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pop) begin
                        sr       <= {1'b1, ~^head, head, 1'b0};
                        ps2_data <= 1'b0;
                        busy     <= 1'b1;
                        nbit     <= '0;
                        tmr      <= DIV_LD;
                        state    <= SETUP;
                    end
                end
                SETUP: begin
                    if (tmr == '0) begin
                        ps2_clk <= 1'b0;
                        tmr     <= DIV_LD;
                        state   <= LOW;
                    end else
                        tmr <= tmr - 1'b1;
                end
                LOW: begin
                    // Ones shift in behind the stop bit, releasing the line after bit 11.
                    if (tmr == '0) begin
                        ps2_clk  <= 1'b1;
                        sr       <= {1'b1, sr[10:1]};
                        ps2_data <= sr[1];
                        nbit     <= nbit + 1'b1;
                        tmr      <= DIV_LD;
                        state    <= HIGH;
                    end else
                        tmr <= tmr - 1'b1;
                end
                HIGH: begin
                    if (tmr == '0) begin
                        if (nbit == 4'd11) begin
                            tmr   <= GAP_LD;
                            state <= GAP;
                        end else begin
                            ps2_clk <= 1'b0;
                            tmr     <= DIV_LD;
                            state   <= LOW;
                        end
                    end else
                        tmr <= tmr - 1'b1;
                end
                GAP: begin
                    if (tmr == '0) begin
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else
                        tmr <= tmr - 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ps2_device_tx.sv
// Bench for ps2_device_tx: frame-level timing model checked every cycle, plus
// a line decoder feeding hand-computed frame/timing expectations.
module tb_ps2_device_tx;
    localparam int CD    = 4;
    localparam int GC    = 8;
    localparam int DEPTH = 4;
    localparam int FRAME = 23 * CD;
    localparam int BUSYC = FRAME + GC;

    logic clk = 1'b0, clrn = 1'b0, wr_en = 1'b0, ovf_clr = 1'b0, host_inhibit = 1'b0;
    logic [7:0] wr_data = '0;
    logic full, empty, busy, overflow, ps2_clk, ps2_data;

    int total = 0, bad = 0;

    ps2_device_tx #(.CLK_DIV(CD), .GAP_CYCLES(GC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .clrn(clrn), .wr_en(wr_en), .wr_data(wr_data), .ovf_clr(ovf_clr),
        .host_inhibit(host_inhibit), .full(full), .empty(empty), .busy(busy),
        .overflow(overflow), .ps2_clk(ps2_clk), .ps2_data(ps2_data)
    );

    always #5 clk = ~clk;

    // Model: FIFO as a queue, an in-flight frame tracked by its cycle offset m_t.
    logic [7:0] mq[$];
    logic [7:0] m_cur = '0;
    logic m_act = 0, m_ovf = 0, m_inh1 = 0, m_inh2 = 0, mvalid = 0;
    int m_t = 0;

    initial forever begin
        logic [10:0] fr;
        logic [5:0] expv, actv;
        logic e_clk, e_dat, m_pop, m_drop;
        int k;
        @(negedge clk);
        if (mvalid) begin
            e_clk = 1'b1;
            e_dat = 1'b1;
            if (m_act && m_t < FRAME) begin
                fr = {1'b1, ~^m_cur, m_cur, 1'b0};
                k  = m_t / (2 * CD);
                if (k < 11) e_dat = fr[k];
                if (m_t >= CD && ((m_t - CD) / CD) % 2 == 0) e_clk = 1'b0;
            end
            expv = {mq.size() == DEPTH, mq.size() == 0, m_act, m_ovf, e_clk, e_dat};
            actv = {full, empty, busy, overflow, ps2_clk, ps2_data};
            total++;
            if (actv !== expv) begin
                bad++;
                $display("FAIL model t=%0t {full,empty,busy,ovf,clk,data} got=%b expected=%b", $time, actv, expv);
            end
        end
        // advance the model by the upcoming rising edge
        if (!clrn) begin
            mq.delete();
            m_act = 0; m_t = 0; m_ovf = 0; m_inh1 = 0; m_inh2 = 0; mvalid = 1;
        end else begin
            m_pop = !m_act && mq.size() > 0 && !m_inh2;
            m_inh2 = m_inh1;
            m_inh1 = host_inhibit;
            if (m_act) begin
                m_t++;
                if (m_t == BUSYC) m_act = 0;
            end
            if (m_pop) begin
                m_cur = mq.pop_front();
                m_act = 1;
                m_t = 0;
            end
            m_drop = wr_en && mq.size() == DEPTH;
            if (wr_en && !m_drop) mq.push_back(wr_data);
            if (ovf_clr) m_ovf = 0;
            if (m_drop) m_ovf = 1;
        end
    end

    // Line decoder: records the data bit at each ps2_clk fall.
    logic [10:0] frames[$];
    int falls[$];
    logic [10:0] fv = '0;
    logic pclk = 1'b1;
    int nb = 0, cyc = 0, busy_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (!clrn)
            nb = 0;
        else if (pclk === 1'b1 && ps2_clk === 1'b0) begin
            fv[nb] = ps2_data;
            falls.push_back(cyc);
            nb++;
            if (nb == 11) begin
                frames.push_back(fv);
                nb = 0;
            end
        end
        pclk = ps2_clk;
        if (busy === 1'b1) busy_cnt++;
        cyc++;
    end

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [7:0] b);
        wr_en = 1'b1;
        wr_data = b;
        tick(1);
        wr_en = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (!(busy == 1'b0 && empty == 1'b1) && n < maxc) begin
            tick(1);
            n++;
        end
        chk("idle_timeout", int'(n < maxc), 1);
    endtask

    task automatic chk_bytes(input string nm, input logic [7:0] b0, input int n);
        logic [10:0] f;
        chk({nm, "_count"}, frames.size(), n);
        for (int i = 0; i < n && i < frames.size(); i++) begin
            f = frames[i];
            chk(nm, int'(f[8:1]), int'(b0 + 8'(i)));
            chk({nm, "_parity"}, int'(f[9]), int'(~^f[8:1]));
        end
    endtask

    initial begin
        int viol, n, sp_bad;
        logic [10:0] f;
        tick(2);
        clrn = 1'b1;
        chk("reset_outputs", int'({full, empty, busy, overflow, ps2_clk, ps2_data}), 'b010011);

        // 1: single byte 0x1C
        frames.delete(); falls.delete(); busy_cnt = 0;
        wr(8'h1C);
        wait_idle(300);
        chk("t1_falls", falls.size(), 11);
        sp_bad = 0;
        for (int i = 1; i < falls.size(); i++)
            if (falls[i] - falls[i-1] != 2 * CD) sp_bad++;
        chk("t1_fall_spacing", sp_bad, 0);
        chk("t1_frame_bits", int'(frames.size() > 0 ? frames[0] : 11'h0), 'h438);
        chk("t1_busy_cycles", busy_cnt, 100);

        // 2: parity of 0x00 / 0xFF and inter-frame spacing
        frames.delete(); falls.delete();
        wr(8'h00);
        wr(8'hFF);
        wait_idle(400);
        chk("t2_frame0", int'(frames.size() > 0 ? frames[0] : 11'h0), 'h600);
        chk("t2_frame1", int'(frames.size() > 1 ? frames[1] : 11'h0), 'h7FE);
        chk("t2_stop_to_start", falls.size() == 22 ? falls[11] - falls[10] : -1, 21);

        // 3: fill, overflow, clear
        frames.delete();
        wr_en = 1'b1;
        for (int i = 1; i <= 5; i++) begin
            wr_data = 8'(i);
            tick(1);
        end
        wr_en = 1'b0;
        chk("t3_full_after5", int'({full, overflow}), 'b10);
        wr(8'h06);
        chk("t3_overflow_set", int'({full, overflow}), 'b11);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        chk("t3_overflow_clr", int'(overflow), 0);
        wait_idle(800);
        chk_bytes("t3_byte", 8'h01, 5);

        // 4: inhibit holds a queued byte; mid-frame inhibit is ignored
        frames.delete();
        host_inhibit = 1'b1;
        tick(3);
        wr(8'h5A);
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            if (!(ps2_clk && ps2_data && !empty)) viol++;
            tick(1);
        end
        chk("t4_inhibit_hold", viol, 0);
        host_inhibit = 1'b0;
        n = 0;
        while (ps2_data == 1'b1 && n < 10) begin
            tick(1);
            n++;
        end
        chk("t4_start_latency_le4", int'(n <= 4), 1);
        tick(30);
        host_inhibit = 1'b1;
        wait_idle(200);
        host_inhibit = 1'b0;
        tick(3);
        chk("t4_frame", int'(frames.size() > 0 ? frames[0] : 11'h0), 'h6B4);

        // 5: reset after the 5th fall of 0xF0
        frames.delete(); falls.delete();
        wr(8'hF0);
        n = 0;
        while (falls.size() < 5 && n < 100) begin
            tick(1);
            n++;
        end
        chk("t5_reach_fall5", int'(n < 100), 1);
        clrn = 1'b0;
        tick(1);
        chk("t5_reset_abort", int'({full, empty, busy, overflow, ps2_clk, ps2_data}), 'b010011);
        clrn = 1'b1;
        tick(1);
        wr(8'h12);
        wait_idle(300);
        chk("t5_frame_count", frames.size(), 1);
        f = frames.size() > 0 ? frames[0] : 11'h0;
        chk("t5_frame", int'(f), 'h624);

        // 6: push coincides with the pop out of a full FIFO
        frames.delete();
        host_inhibit = 1'b1;
        tick(3);
        wr_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wr_data = 8'hA1 + 8'(i);
            tick(1);
        end
        wr_en = 1'b0;
        chk("t6_full", int'(full), 1);
        host_inhibit = 1'b0;
        tick(2);
        wr_en = 1'b1;
        wr_data = 8'hA5;
        tick(1);
        wr_en = 1'b0;
        chk("t6_push_pop", int'({full, busy, overflow}), 'b110);
        wait_idle(800);
        chk_bytes("t6_byte", 8'hA1, 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end
endmodule

// File: doc/ps2_device_tx.md
Name: ps2_device_tx

Overview:
- PS/2 device-side transmitter: the keyboard end of the link. Serialises buffered scan-code bytes into standard 11-bit PS/2 frames, generating both ps2_clk and ps2_data.
- Buffers bytes in a small FIFO and supports host inhibit.
- Used as the stimulus source for ps2_keyboard in simulation and on-board loopback, so the receiver path can be exercised without a physical keyboard.

Parameters:
- CLK_DIV, 8: system clock cycles per ps2_clk half-period (low phase = high phase = CLK_DIV); must be >= 2.
- GAP_CYCLES, 16: idle cycles inserted after each frame's stop bit before the next frame may start; must be >= 1.
- FIFO_DEPTH, 8: byte FIFO depth; power of two, >= 2.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- clrn  input  1  synchronous active-low reset.
- wr_en  input  1  write strobe; pushes wr_data when FIFO not full.
- wr_data  input  8  scan-code byte to transmit.
- ovf_clr  input  1  clears sticky overflow.
- host_inhibit  input  1  asynchronous host request that the device not start a frame; 2-flop synchronised internally.
- full  output  1  FIFO holds FIFO_DEPTH bytes.
- empty  output  1  FIFO holds 0 bytes.
- busy  output  1  frame or gap in progress.
- overflow  output  1  sticky: a write was dropped.
- ps2_clk  output  1  PS/2 clock, idle high.
- ps2_data  output  1  PS/2 data, idle high.

Behaviour:
- Reset (clrn=0 at rising edge) applies these values:
  - ps2_clk=1, ps2_data=1, busy=0, overflow=0, full=0, empty=1.
  - FIFO pointers and count = 0, FSM = IDLE, inhibit synchroniser = 0.
  - Reset mid-frame aborts the frame immediately; the remaining bits are never sent.
- All outputs are registered.
- FIFO write rules:
  - A write is accepted if wr_en=1 and (count<FIFO_DEPTH or a pop occurs in the same cycle).
  - wr_en=1 with count=FIFO_DEPTH and no pop: byte dropped, overflow<=1.
  - overflow stays set until ovf_clr=1. If set and clear coincide, set wins.
  - A simultaneous push and pop leaves the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
- Frame format: start 0, data bits D0..D7 LSB first, odd parity (~^data), stop 1.
- FSM states: IDLE, SETUP, LOW, HIGH, GAP. The down-counter reloads CLK_DIV-1 (GAP_CYCLES-1 in GAP) on every state entry.
- IDLE:
  - If FIFO non-empty and synchronised inhibit=0: pop the head byte, load the 11-bit shift register, drive ps2_data=start bit, busy<=1, go to SETUP.
  - The frame starts one cycle after the write that made the FIFO non-empty, inhibit permitting.
- SETUP: ps2_clk=1 for CLK_DIV cycles, then LOW.
- LOW: ps2_clk=0 for CLK_DIV cycles; ps2_data is held constant. The receiver samples on the falling edge at LOW entry. Then go to HIGH.
- HIGH:
  - On entry, ps2_clk=1 and the shift register advances; ps2_data takes the next bit.
  - After the 11th LOW phase, ps2_data=1 (line released).
  - After CLK_DIV cycles: go to LOW if bits remain, otherwise to GAP.
- GAP: ps2_clk=1, ps2_data=1 for GAP_CYCLES cycles, then IDLE. busy<=0 on IDLE entry.
- Frame timing:
  - 11 falling edges per frame.
  - Start to stop-bit end is CLK_DIV + 22*CLK_DIV cycles.
  - Back-to-back frames are separated by GAP_CYCLES cycles plus one IDLE cycle.
- host_inhibit:
  - Checked only in IDLE; a frame in progress always completes.
  - Bytes remain queued while inhibit is asserted, and writes are still accepted.
- ps2_clk and ps2_data never glitch: each changes at most once per state entry.

Test Plan:
Run with CLK_DIV=4, GAP_CYCLES=8, FIFO_DEPTH=4.
1. Single byte: write 0x1C after reset.
   - Required: 11 ps2_clk falling edges, 8 cycles apart.
   - ps2_data at each fall = 0,0,0,1,1,1,0,0,0,0,1 (parity 0).
   - busy high for 92+8 cycles.
   - A connected ps2_keyboard presents data=0x1C with ready=1.
2. Parity: write 0x00 then 0xFF.
   - Required: parity bits 1 then 1.
   - Exactly 8+1 idle cycles between the stop of frame 1 and the start of frame 2.
3. FIFO full/overflow: 5 consecutive writes 0x01..0x05 while idle.
   - Required: the first write is popped, so 0x01..0x05 all accepted with no overflow.
   - A 6th write while full is dropped: overflow=1, full=1.
   - Transmitted sequence is exactly 0x01..0x05.
   - ovf_clr for one cycle then clears overflow.
4. Inhibit: assert host_inhibit, write 0x5A.
   - Required: ps2_clk and ps2_data stay 1 and empty=0 for 100 cycles.
   - After deassertion, the frame starts within 4 cycles and sends 0x5A with parity 1.
   - Inhibit asserted mid-frame leaves that frame intact.
5. Reset mid-frame: clrn=0 after the 5th falling edge of 0xF0.
   - Required: ps2_clk=1, ps2_data=1, busy=0, empty=1 on the next edge.
   - The next write 0x12 produces a clean, complete frame.
6. Simultaneous push/pop: FIFO full with 4 bytes and an IDLE pop coinciding with wr_en.
   - Required: write accepted, count stays 4, no overflow.
